// File: rtl/rca_sweep_checker.sv
// Exhaustive stimulus/response checker for a ripple-carry adder: sweeps every operand
// vector, compares {Cout,S} with A+B+Cin and reports the result. Define RCA_SWEEP_CIN_EN to add a Cin=1 pass.
module rca_sweep_checker #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SETTLE = 2
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Start,
   output logic [WIDTH-1:0]     A,
   output logic [WIDTH-1:0]     B,
   output logic                 Cin,
   input  logic [WIDTH-1:0]     S,
   input  logic                 Cout,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Pass,
   output logic [2*WIDTH+1:0]   ErrCount,
   output logic [WIDTH-1:0]     FailA,
   output logic [WIDTH-1:0]     FailB,
   output logic                 FailCin
);

   localparam int unsigned EW = 2 * WIDTH + 2;
   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
   localparam logic [WIDTH-1:0] OPND_MAX = '1;
   localparam logic [EW-1:0]    ERR_MAX  = '1;

   if (SETTLE == 0) begin : g_settle_chk
      $error("rca_sweep_checker: SETTLE must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             cin_q, cin_d;
   logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [EW-1:0]    err_q, err_d;
   logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
   logic             fail_cin_q, fail_cin_d;
   logic             first_q, first_d;

   logic [WIDTH:0]   sum_exp_c;
   logic             mismatch_c;
   logic             last_c;
   logic [EW-1:0]    err_next_c;

   // Reference sum and end-of-sweep detection for the vector currently driven.
   always_comb begin
      sum_exp_c  = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
      mismatch_c = ({Cout, S} != sum_exp_c);
`ifdef RCA_SWEEP_CIN_EN
      last_c     = (a_q == OPND_MAX) && (b_q == OPND_MAX) && cin_q;
`else
      last_c     = (a_q == OPND_MAX) && (b_q == OPND_MAX);
`endif
      err_next_c = (mismatch_c && (err_q != ERR_MAX)) ? err_q + EW'(1) : err_q;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      cin_d      = cin_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      err_d      = err_q;
      fail_a_d   = fail_a_q;
      fail_b_d   = fail_b_q;
      fail_cin_d = fail_cin_q;
      first_d    = first_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               a_d        = '0;
               b_d        = '0;
               cin_d      = 1'b0;
               err_d      = '0;
               fail_a_d   = '0;
               fail_b_d   = '0;
               fail_cin_d = 1'b0;
               first_d    = 1'b0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               cnt_d      = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_CHECK: begin
            err_d = err_next_c;
            if (mismatch_c && !first_q) begin
               first_d    = 1'b1;
               fail_a_d   = a_q;
               fail_b_d   = b_q;
               fail_cin_d = cin_q;
            end
            if (last_c) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_next_c == '0);
               state_d = S_DONE;
            end else begin
               // B is the fast index; A steps on B wrap, Cin on A/B wrap.
               b_d = b_q + WIDTH'(1);
               if (b_q == OPND_MAX) begin
                  a_d = a_q + WIDTH'(1);
`ifdef RCA_SWEEP_CIN_EN
                  if (a_q == OPND_MAX) cin_d = 1'b1;
`endif
               end
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         cin_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         fail_a_q   <= '0;
         fail_b_q   <= '0;
         fail_cin_q <= 1'b0;
         first_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cin_q      <= cin_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         fail_a_q   <= fail_a_d;
         fail_b_q   <= fail_b_d;
         fail_cin_q <= fail_cin_d;
         first_q    <= first_d;
      end
   end

   assign A        = a_q;
   assign B        = b_q;
   assign Cin      = cin_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Pass     = pass_q;
   assign ErrCount = err_q;
   assign FailA    = fail_a_q;
   assign FailB    = fail_b_q;
   assign FailCin  = fail_cin_q;

endmodule

// File: doc/rca_sweep_checker.md
# rca_sweep_checker

- Self-checking exhaustive stimulus/response stage wrapped around the ripple-carry adder.
- Drives `A`, `B` and `Cin` into the adder and captures `{Cout,S}` after a programmable settle time.
- Compares each result against `A+B+Cin` and reports a pass/fail summary, an error count and the first failing vector.
- Sits directly upstream (operand source) and downstream (result consumer) of the adder.

## Interface

- `WIDTH`, 8: operand width; must match the adder.
- `SETTLE`, 2: cycles operands are held before the result is sampled; must be ≥1.
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  starts a sweep when sampled high in IDLE or DONE.
- A  out  WIDTH  operand A to the adder (registered).
- B  out  WIDTH  operand B to the adder (registered).
- Cin  out  1  carry-in to the adder (registered).
- S  in  WIDTH  sum from the adder.
- Cout  in  1  carry-out from the adder.
- Busy  out  1  high while a sweep is running.
- Done  out  1  high from sweep completion until the next accepted Start or reset.
- Pass  out  1  valid when Done=1; high iff ErrCount==0.
- ErrCount  out  2*WIDTH+2  number of mismatching vectors; saturates at all-ones.
- FailA  out  WIDTH  A of the first mismatch; 0 if none.
- FailB  out  WIDTH  B of the first mismatch; 0 if none.
- FailCin  out  1  Cin of the first mismatch; 0 if none.

## Operation

- FSM states:
  - IDLE: Busy=0, Done=0.
  - WAIT: holds the current vector and counts settle cycles.
  - CHECK: samples and compares the result.
  - DONE: Busy=0, Done=1.
- Start accepted in IDLE or DONE:
  - A=B=0, Cin=0.
  - Clear ErrCount, Fail* and an internal first-fail flag.
  - Busy=1, Done=0, go to WAIT.
- Start is ignored in WAIT and CHECK.
- WAIT lasts exactly SETTLE cycles, then the FSM goes to CHECK.
- CHECK lasts 1 cycle and compares `{Cout,S}` against `A+B+Cin`, computed at WIDTH+1 bits.
  - On mismatch: ErrCount increments (unless already all-ones).
  - On the first mismatch only: A/B/Cin are latched into FailA/FailB/FailCin.
- After CHECK:
  - If the vector was the last one, go to DONE: Busy=0, Done=1, Pass=(ErrCount_next==0).
  - Otherwise advance the vector and go to WAIT.
- Vector order:
  - B increments fastest.
  - When B wraps from 2^WIDTH−1 to 0, A increments.
  - The last vector of a pass is A=B=2^WIDTH−1.
- DONE holds all outputs stable until Start or reset; A, B and Cin stay at the last vector.

## Timing

- Every output is registered.
- Reset values: A=0, B=0, Cin=0, Busy=0, Done=0, Pass=0, ErrCount=0, FailA=0, FailB=0, FailCin=0; FSM in IDLE.
- The edge that samples Start high sets Busy and presents vector 0.
- Each vector is held for SETTLE+1 cycles. S/Cout are sampled on the edge that ends CHECK.
- Sweep length is N·(SETTLE+1) cycles of Busy=1, with N=2^(2·WIDTH) or twice that (see Configuration).
- Busy falls and Done rises on the same edge.
- Reset asserted mid-sweep immediately forces all reset values; no partial results are retained.
- Start held high continuously:
  - Ignored during the sweep.
  - Re-triggers a sweep on the first cycle in DONE (Done is then high for 1 cycle).

## Configuration

- `RCA_SWEEP_CIN_EN` defined: two passes.
  - First pass: Cin=0 over all A/B.
  - Second pass: Cin=1 over all A/B.
  - N=2^(2·WIDTH+1). The last vector is A=B=all-ones with Cin=1.
- `RCA_SWEEP_CIN_EN` undefined: single pass with Cin tied to 0.
  - N=2^(2·WIDTH).
  - FailCin is always 0.

## Test plan

All cases use WIDTH=8 and SETTLE=2 unless stated.

- Ideal adder model, macro off, single Start pulse -> Busy high for 196608 cycles, then Done=1, Pass=1, ErrCount=0, FailA=FailB=0.
- Adder with S[0] stuck at 0, macro off -> ErrCount=32768, Pass=0, FailA=0, FailB=1.
- Adder with Cout stuck at 0, macro off -> ErrCount=32640, FailA=1, FailB=255.
- Adder with Cout stuck at 0, macro on -> ErrCount=65536, FailA=1, FailB=255, FailCin=0; Busy lasts 393216 cycles.
- Start pulsed mid-sweep, then Rst_n low for 1 cycle mid-sweep:
  - The Start pulse does not restart the sweep.
  - The reset returns every output to its reset value asynchronously.
  - A fresh Start afterwards completes with Pass=1 on the ideal adder.
- WIDTH=2, SETTLE=1, ideal adder with a 1-cycle registered result, macro off -> Pass=1; the same adder with SETTLE=0 forbidden by parameter check at elaboration.
